// File: rtl/hazard_pkg.sv
// Shared types for the pipeline stall/flush scheduler.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MD_BUSY  = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

    // One bit per pipeline-register control, ordered F, D, E, M stalls then D, E, M, W flushes.
    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
        logic flush_m;
        logic flush_w;
    } hz_ctl_t;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Pair of free-running wrap-around event counters for stall/flush statistics.
module hazard_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_stall,
    input  logic             inc_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Next counts: increment on enable, wrapping naturally at 2^CNT_W.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (inc_stall) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (inc_flush) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    // Counter registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush scheduler: load-use bubbles, branch flushes, mul/div occupancy, data-memory waits.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   RUN      | normal flow; single-cycle hazards resolved combinationally
//   MD_BUSY  | mul/div still occupying Execute, mdcnt stalled cycles left
//   MEM_WAIT | data memory not ready; ret_md selects state to resume into
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int MULDIV_CYCLES = 4,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdE,
    input  logic             MemReadE,
    input  logic             PCSrcE,
    input  logic             MulDivE,
    input  logic             DMemReqM,
    input  logic             DMemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             FlushW,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCount
);

    localparam int MDW = $clog2(MULDIV_CYCLES) + 1;
    // With a single-cycle mul/div there is nothing to stall for, so the start path is disabled.
    localparam bit MD_EN   = (MULDIV_CYCLES >= 2);
    localparam int MD_LOAD = MD_EN ? (MULDIV_CYCLES - 2) : 0;

    hz_state_t        state_q, state_d, eff_state;
    logic [MDW-1:0]   mdcnt_q, mdcnt_d;
    logic             ret_md_q, ret_md_d;
    logic             memwait, load_use;
    hz_ctl_t          ctl;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    // Next-state and control outputs; a memory wait overrides everything else.
    always_comb begin
        state_d   = state_q;
        mdcnt_d   = mdcnt_q;
        ret_md_d  = ret_md_q;
        ctl       = '0;
        memwait   = DMemReqM & ~DMemReadyM;
        load_use  = MemReadE && (RdE != REG_X0) && ((RdE == Rs1D) || (RdE == Rs2D));
        // The cycle a memory wait ends behaves exactly like the state being resumed.
        eff_state = state_q;
        if (state_q == MEM_WAIT) eff_state = ret_md_q ? MD_BUSY : RUN;

        if (memwait) begin
            ctl.stall_f = 1'b1;
            ctl.stall_d = 1'b1;
            ctl.stall_e = 1'b1;
            ctl.stall_m = 1'b1;
            ctl.flush_w = 1'b1;
            state_d     = MEM_WAIT;
            if (state_q == RUN)     ret_md_d = 1'b0;
            if (state_q == MD_BUSY) ret_md_d = 1'b1;
        end else begin
            case (eff_state)
                MD_BUSY: begin
                    if (mdcnt_q != '0) begin
                        ctl.stall_f = 1'b1;
                        ctl.stall_d = 1'b1;
                        ctl.stall_e = 1'b1;
                        ctl.flush_m = 1'b1;
                        mdcnt_d     = mdcnt_q - MDW'(1);
                        state_d     = MD_BUSY;
                    end else begin
                        // Execute is released; a branch held behind the mul/div resolves now.
                        state_d     = RUN;
                        ctl.flush_d = PCSrcE;
                        ctl.flush_e = PCSrcE;
                    end
                end
                default: begin
                    state_d = RUN;
                    if (PCSrcE) begin
                        ctl.flush_d = 1'b1;
                        ctl.flush_e = 1'b1;
                    end else if (MulDivE && MD_EN) begin
                        ctl.stall_f = 1'b1;
                        ctl.stall_d = 1'b1;
                        ctl.stall_e = 1'b1;
                        ctl.flush_m = 1'b1;
                        mdcnt_d     = MDW'(MD_LOAD);
                        state_d     = MD_BUSY;
                    end else if (load_use) begin
                        ctl.stall_f = 1'b1;
                        ctl.stall_d = 1'b1;
                        ctl.flush_e = 1'b1;
                    end
                end
            endcase
        end

        if (!rst_n) ctl = '0;
    end

    // State registers; reset abandons any in-flight mul/div or memory wait.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= RUN;
            mdcnt_q  <= '0;
            ret_md_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mdcnt_q  <= mdcnt_d;
            ret_md_q <= ret_md_d;
        end
    end

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_perf (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc_stall (ctl.stall_f),
        .inc_flush (ctl.flush_d),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    assign StallF      = ctl.stall_f;
    assign StallD      = ctl.stall_d;
    assign StallE      = ctl.stall_e;
    assign StallM      = ctl.stall_m;
    assign FlushD      = ctl.flush_d;
    assign FlushE      = ctl.flush_e;
    assign FlushM      = ctl.flush_m;
    assign FlushW      = ctl.flush_w;
    assign StallCycles = rst_n ? stall_cnt : '0;
    assign FlushCount  = rst_n ? flush_cnt : '0;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl; second instance covers a single-cycle mul/div.
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  Rs1D, Rs2D, RdE;
    logic        MemReadE, PCSrcE, MulDivE, DMemReqM, DMemReadyM;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW;
    logic [31:0] StallCycles, FlushCount;
    logic        StallF1, StallD1, StallE1, StallM1, FlushD1, FlushE1, FlushM1, FlushW1;
    logic [31:0] StallCycles1, FlushCount1;
    logic [7:0]  ctl, ctl1;

    int n_tests = 0;
    int n_fail  = 0;

    // Order: StallF StallD StallE StallM FlushD FlushE FlushM FlushW
    localparam logic [7:0] C_IDLE = 8'b0000_0000;
    localparam logic [7:0] C_LU   = 8'b1100_0100;
    localparam logic [7:0] C_BR   = 8'b0000_1100;
    localparam logic [7:0] C_MD   = 8'b1110_0010;
    localparam logic [7:0] C_MEM  = 8'b1111_0001;

    assign ctl  = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW};
    assign ctl1 = {StallF1, StallD1, StallE1, StallM1, FlushD1, FlushE1, FlushM1, FlushW1};

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MULDIV_CYCLES(4), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE),
        .MemReadE(MemReadE), .PCSrcE(PCSrcE), .MulDivE(MulDivE),
        .DMemReqM(DMemReqM), .DMemReadyM(DMemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
        .StallCycles(StallCycles), .FlushCount(FlushCount)
    );

    hazard_stall_ctrl #(.MULDIV_CYCLES(1), .CNT_W(32)) dut1 (
        .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE),
        .MemReadE(MemReadE), .PCSrcE(PCSrcE), .MulDivE(MulDivE),
        .DMemReqM(DMemReqM), .DMemReadyM(DMemReadyM),
        .StallF(StallF1), .StallD(StallD1), .StallE(StallE1), .StallM(StallM1),
        .FlushD(FlushD1), .FlushE(FlushE1), .FlushM(FlushM1), .FlushW(FlushW1),
        .StallCycles(StallCycles1), .FlushCount(FlushCount1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        Rs1D = 5'd0; Rs2D = 5'd0; RdE = 5'd0;
        MemReadE = 1'b0; PCSrcE = 1'b0; MulDivE = 1'b0;
        DMemReqM = 1'b0; DMemReadyM = 1'b0;
    endtask

    // Advance to just after the next rising edge, then let combinational outputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        tick();
        MulDivE = 1'b1;
        settle();
        chk("reset_ctl", 32'(ctl), 32'(C_IDLE));
        chk("reset_stallcnt", StallCycles, 32'd0);
        chk("reset_flushcnt", FlushCount, 32'd0);
        tick();
        rst_n = 1'b1;
        idle();
        settle();
        chk("post_reset_ctl", 32'(ctl), 32'(C_IDLE));

        // Load-use on rs2
        MemReadE = 1'b1; RdE = 5'd5; Rs2D = 5'd5;
        settle();
        chk("loaduse_ctl", 32'(ctl), 32'(C_LU));
        tick();
        idle();
        settle();
        chk("loaduse_after", 32'(ctl), 32'(C_IDLE));
        chk("loaduse_stallcnt", StallCycles, 32'd1);
        // Load to x0 is not a hazard
        MemReadE = 1'b1; RdE = 5'd0; Rs2D = 5'd0;
        settle();
        chk("loaduse_x0", 32'(ctl), 32'(C_IDLE));
        tick();
        idle();

        // Taken branch in RUN
        PCSrcE = 1'b1;
        settle();
        chk("branch_ctl", 32'(ctl), 32'(C_BR));
        tick();
        idle();
        settle();
        chk("branch_after", 32'(ctl), 32'(C_IDLE));
        chk("branch_flushcnt", FlushCount, 32'd1);
        chk("branch_stallcnt", StallCycles, 32'd1);

        // Branch coinciding with load-use: flush wins, no F/D stall
        PCSrcE = 1'b1; MemReadE = 1'b1; RdE = 5'd7; Rs1D = 5'd7;
        settle();
        chk("br_lu_ctl", 32'(ctl), 32'(C_BR));
        tick();
        idle();
        settle();
        chk("br_lu_flushcnt", FlushCount, 32'd2);

        // Mul/div, 4 cycles in Execute: 3 stalled, released on 4th
        MulDivE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk($sformatf("md_stall_%0d", i), 32'(ctl), 32'(C_MD));
            chk($sformatf("md1_nostall_%0d", i), 32'(ctl1), 32'(C_IDLE));
            tick();
        end
        settle();
        chk("md_release", 32'(ctl), 32'(C_IDLE));
        tick();
        idle();
        settle();
        chk("md_stallcnt", StallCycles, 32'd4);
        chk("md1_stallcnt", StallCycles1, 32'd1);

        // Mem wait in 2nd MD_BUSY cycle for 2 cycles; mdcnt must freeze
        MulDivE = 1'b1;
        settle();
        chk("mdmw_c1", 32'(ctl), 32'(C_MD));
        tick();
        settle();
        chk("mdmw_c2", 32'(ctl), 32'(C_MD));
        tick();
        DMemReqM = 1'b1; DMemReadyM = 1'b0;
        settle();
        chk("mdmw_c3", 32'(ctl), 32'(C_MEM));
        tick();
        settle();
        chk("mdmw_c4", 32'(ctl), 32'(C_MEM));
        tick();
        DMemReadyM = 1'b1;
        settle();
        chk("mdmw_c5_resume", 32'(ctl), 32'(C_MD));
        tick();
        DMemReqM = 1'b0; DMemReadyM = 1'b0;
        settle();
        chk("mdmw_c6_release", 32'(ctl), 32'(C_IDLE));
        tick();
        idle();
        settle();
        chk("mdmw_stallcnt", StallCycles, 32'd9);
        chk("mdmw_md1_stallcnt", StallCycles1, 32'd3);

        // Branch deferred behind a 3-cycle memory wait
        PCSrcE = 1'b1; DMemReqM = 1'b1; DMemReadyM = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk($sformatf("defbr_wait_%0d", i), 32'(ctl), 32'(C_MEM));
            tick();
        end
        DMemReadyM = 1'b1;
        settle();
        chk("defbr_fire", 32'(ctl), 32'(C_BR));
        tick();
        idle();
        settle();
        chk("defbr_after", 32'(ctl), 32'(C_IDLE));
        chk("defbr_flushcnt", FlushCount, 32'd3);
        chk("defbr_stallcnt", StallCycles, 32'd12);

        // Reset in the middle of a mul/div
        MulDivE = 1'b1;
        settle();
        chk("rstmd_start", 32'(ctl), 32'(C_MD));
        tick();
        rst_n = 1'b0;
        settle();
        chk("rstmd_ctl", 32'(ctl), 32'(C_IDLE));
        chk("rstmd_stallcnt", StallCycles, 32'd0);
        tick();
        rst_n = 1'b1;
        MulDivE = 1'b0;
        settle();
        chk("rstmd_after_ctl", 32'(ctl), 32'(C_IDLE));
        chk("rstmd_after_stallcnt", StallCycles, 32'd0);
        chk("rstmd_after_flushcnt", FlushCount, 32'd0);
        tick();
        settle();
        chk("rstmd_run_ctl", 32'(ctl), 32'(C_IDLE));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline stall/flush scheduler for the 5-stage RISC-V core. It owns all StallX/FlushX controls that complement operand forwarding:
- load-use bubbles
- branch/jump flushes
- fixed-latency mul/div occupancy of Execute
- data-memory wait freezes

A small FSM remembers multi-cycle conditions, and two performance counters expose the stall and flush statistics.

Parameters:
MULDIV_CYCLES, 4, total cycles a mul/div instruction occupies Execute (>=1; 1 means no stall)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  synchronous active-low reset
Rs1D  in  5  rs1 of instruction in Decode
Rs2D  in  5  rs2 of instruction in Decode
RdE  in  5  rd of instruction in Execute
MemReadE  in  1  instruction in Execute is a load
PCSrcE  in  1  taken branch/jump resolved in Execute
MulDivE  in  1  instruction in Execute is mul/div
DMemReqM  in  1  Memory stage has an active data access
DMemReadyM  in  1  data memory completes access this cycle
StallF  out  1  hold PC
StallD  out  1  hold IF/ID
StallE  out  1  hold ID/EX
StallM  out  1  hold EX/MEM
FlushD  out  1  clear IF/ID
FlushE  out  1  clear ID/EX
FlushM  out  1  clear EX/MEM (bubble)
FlushW  out  1  clear MEM/WB (bubble)
StallCycles  out  CNT_W  cycles with StallF=1
FlushCount  out  CNT_W  cycles with FlushD=1

Behaviour:
- State reg: RUN, MD_BUSY, MEM_WAIT. Also mdcnt (clog2(MULDIV_CYCLES)+1 bits) and ret_md (1 bit, MD_BUSY to resume after MEM_WAIT).
- Outputs combinational from state, mdcnt and inputs. All outputs forced 0 while rst_n=0.
- Reset (sync): state=RUN, mdcnt=0, ret_md=0, both counters=0. Reset mid mul/div or mid mem-wait abandons it; no stall is asserted in the first cycle after release.
- memwait = DMemReqM & !DMemReadyM. Highest priority in every state.
  - When memwait=1: StallF=StallD=StallE=StallM=1, FlushW=1, all other flushes 0, mdcnt frozen.
  - Entering MEM_WAIT from MD_BUSY sets ret_md=1; entering from RUN clears it.
- MEM_WAIT:
  - While memwait=1: stay.
  - When DMemReadyM=1: no mem stall that cycle; next state is MD_BUSY if ret_md, else RUN. All other outputs that cycle are evaluated as in the return state.
- Mul/div start (RUN, MulDivE=1, memwait=0, MULDIV_CYCLES>=2):
  - StallF=StallD=StallE=1, FlushM=1.
  - Load mdcnt=MULDIV_CYCLES-2, go MD_BUSY.
- MD_BUSY, memwait=0:
  - mdcnt!=0: same stalls, FlushM=1, mdcnt--.
  - mdcnt==0: no stalls, go RUN.
  - MulDivE is ignored in MD_BUSY.
  - Net effect: MULDIV_CYCLES-1 stalled cycles, Execute occupied for exactly MULDIV_CYCLES cycles.
- Load-use (RUN only, memwait=0): MemReadE & RdE!=0 & (RdE==Rs1D | RdE==Rs2D) gives StallF=StallD=1, FlushE=1. Purely combinational, one cycle, no state change.
- Branch (RUN or MD_BUSY release cycle, memwait=0): PCSrcE gives FlushD=FlushE=1. While StallE=1 the flush is deferred and asserted once Execute is released.
- Priority with memwait=0: branch flush > mul/div start > load-use. When a branch flush and a load-use detection coincide, StallF=StallD=0.
- Counters:
  - StallCycles += 1 each cycle StallF=1; FlushCount += 1 each cycle FlushD=1.
  - Both wrap modulo 2^CNT_W and are not incremented while rst_n=0.

Decomposition:
- hazard_pkg: state enum (RUN/MD_BUSY/MEM_WAIT), stall/flush bundle struct, REG_X0 constant 5'd0.
- One sub-module, hazard_perf_cnt: the two saturating-free wrap counters with enable inputs.

Test Plan:
- Load-use: MemReadE=1, RdE=5, Rs2D=5, others idle -> one cycle StallF=StallD=FlushE=1, then all 0; StallCycles=1. Repeat with RdE=0 -> no stall.
- Branch: PCSrcE=1 for one cycle in RUN -> FlushD=FlushE=1 that cycle only; FlushCount increments 0->1; no stalls.
- Mul/div, MULDIV_CYCLES=4: MulDivE held high for 4 cycles -> StallF/D/E=1 and FlushM=1 for exactly 3 cycles, released in 4th; StallCycles=3. MULDIV_CYCLES=1 -> no stall.
- Mem wait during mul/div: DMemReqM=1, DMemReadyM=0 for 2 cycles in 2nd MD_BUSY cycle -> all four stalls plus FlushW for 2 cycles, mdcnt frozen. Mul/div then finishes with its remaining count; total StallF cycles = 5.
- Deferred branch: PCSrcE=1 while memwait active 3 cycles -> FlushD/FlushE stay 0 until DMemReadyM=1 cycle, then assert once.
- Reset mid MD_BUSY: rst_n=0 for 1 cycle -> outputs 0 that cycle, state RUN, counters 0. MulDivE low after reset -> no stall.
